graph_plot_sequencer: RTL and testbench
=======================================

GRAPH_PLOT_SEQUENCER -- requirements
Module: graph_plot_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NUM_COLS, 620, graph columns to plot.
- X_MIN, -310, signed x value for column 0.
- TIMEOUT, 255, evaluator wait limit in cycles.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, system clock; the only clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle pulse to begin a plot sweep (equals key).
- abort, in, 1, one-cycle pulse to cancel the sweep (clear key).
- eval_req, out, 1, request to the expression evaluator.
- eval_x, out, 16, signed x operand, two's complement.
- eval_ack, in, 1, evaluator result valid.
- eval_y, in, 16, signed y result.
- eval_err, in, 1, evaluation failed (div0/overflow).
- col_we, out, 1, column buffer write strobe.
- col_addr, out, 10, column buffer address.
- col_data, out, 17, {valid, y[15:0]}.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle sweep-complete pulse.
- err_count, out, 10, count of columns that failed evaluation.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WRITE and DONE, one-hot or encoded.
REQ-004 In IDLE, start=1 with abort=0 SHALL load col=0, x=X_MIN and err_count=0, then move to REQ on the next cycle.
REQ-005 In REQ, eval_req SHALL be 1 and eval_x SHALL hold x unchanged until eval_ack=1 is sampled.
REQ-006 On that ack, the block SHALL capture eval_y/eval_err and move to WRITE.
REQ-007 eval_ack sampled in any state other than REQ SHALL be ignored.
REQ-008 In WRITE, col_we SHALL be 1 for exactly one cycle, with col_addr=col and col_data={~err, y}.
REQ-009 After WRITE, if col==NUM_COLS-1 the FSM SHALL go to DONE; otherwise it SHALL increment col and x by 1 and return to REQ.
REQ-010 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-011 busy SHALL be 1 in REQ, WRITE and DONE, and 0 in IDLE.
REQ-012 Latency: eval_req SHALL rise on the cycle after start.
REQ-013 Each column SHALL take at least 2 cycles, so a full sweep with immediate acks takes 2*NUM_COLS+1 cycles from start to the done pulse.
REQ-014 err_count SHALL increment once per WRITE with err=1 and saturate at 1023.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 abort in any non-IDLE state SHALL force IDLE on the next cycle, with no col_we and no done; a WRITE coinciding with abort SHALL be suppressed.
REQ-017 abort and start asserted in the same IDLE cycle: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-018 eval_x SHALL be computed with 16-bit wrap-around; no saturation is required because the x range fits in 16 bits.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE.
REQ-020 On reset, eval_req, col_we, done and busy SHALL be 0, and col_addr, col_data, eval_x and err_count SHALL be 0.
REQ-021 reset SHALL override start and abort.
REQ-022 Reset mid-sweep SHALL discard the sweep with no further writes.

Configuration
REQ-023 With GRAPH_EVAL_TIMEOUT_EN defined, a cycle counter SHALL run in REQ, cleared on entry to REQ.
REQ-024 With GRAPH_EVAL_TIMEOUT_EN defined, if TIMEOUT cycles elapse without eval_ack, the block SHALL treat the column as err=1: drop eval_req, go to WRITE with col_data={0, 16'h0000}, and increment err_count.
REQ-025 Without GRAPH_EVAL_TIMEOUT_EN, REQ SHALL wait indefinitely and no counter logic SHALL be synthesised.

Verification
REQ-026 Scenario 1: NUM_COLS=4, evaluator acks in the same cycle with y=x*2, start at cycle 0. Required: writes at addr 0..3 with data {1, -620}, {1, -618}, {1, -616}, {1, -614}; done at cycle 9; err_count=0.
REQ-027 Scenario 2: column 2 returns eval_err=1. Required: addr 2 gets valid bit 0; err_count=1 at done.
REQ-028 Scenario 3: ack delayed 5 cycles. Required: eval_req and eval_x stable for all 5 cycles; exactly one col_we per column.
REQ-029 Scenario 4: abort during column 1 REQ. Required: busy=0 next cycle; no further col_we; no done; a second start is accepted and restarts at addr 0.
REQ-030 Scenario 5: start pulsed mid-sweep, then reset mid-sweep. Required: the mid-sweep start is ignored; after reset all outputs are 0 and the state is IDLE.
REQ-031 Scenario 6 (GRAPH_EVAL_TIMEOUT_EN, TIMEOUT=8): no ack. Required: col_we 9 cycles after entering REQ with data 17'h00000; err_count increments.

Source files
------------

// File: rtl/graph_plot_sequencer.sv
// graph_plot_sequencer
// Walks the graph columns left to right. For each column it asks the
// expression evaluator for y(x), then writes {valid, y} into the column
// buffer, and raises done once the last column has been written.
// Optional feature: define GRAPH_EVAL_TIMEOUT_EN to give up on an evaluator
// that never acks. After TIMEOUT cycles in REQ the column is marked invalid.
module graph_plot_sequencer #(
   parameter int NUM_COLS = 620,
   parameter int X_MIN    = -310,
   parameter int TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic        eval_req,
   output logic [15:0] eval_x,
   input  logic        eval_ack,
   input  logic [15:0] eval_y,
   input  logic        eval_err,
   output logic        col_we,
   output logic [9:0]  col_addr,
   output logic [16:0] col_data,
   output logic        busy,
   output logic        done,
   output logic [9:0]  err_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [9:0] LAST_COL = 10'(NUM_COLS - 1);
   localparam logic [9:0] ERR_MAX  = 10'd1023;

   state_t      r_state;
   state_t      w_nextState;
   logic [9:0]  r_col;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic        r_err;
   logic [9:0]  r_errCount;
   logic        w_lastCol;
   logic        w_timeout;
   logic        w_startAccepted;

   assign w_lastCol       = (r_col == LAST_COL);
   assign w_startAccepted = (r_state == S_IDLE) && start && !abort;

`ifdef GRAPH_EVAL_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_waitCnt;

   assign w_timeout = (r_state == S_REQ) && !eval_ack && (r_waitCnt == CNT_W'(TIMEOUT));

   // The wait counter sits at zero outside REQ, so each REQ visit starts counting from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitCnt <= '0;
      end else if (r_state != S_REQ) begin
         r_waitCnt <= '0;
      end else if (!w_timeout) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end
`else
   logic w_unusedTimeout;

   assign w_unusedTimeout = ^TIMEOUT;
   assign w_timeout       = 1'b0;
`endif

   // State register. Reset has priority over start and abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. In IDLE, abort beats start. In every other state, abort drops the sweep.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_nextState = S_REQ;
            end
         end
         S_REQ: begin
            if (abort) begin
               w_nextState = S_IDLE;
            end else if (eval_ack || w_timeout) begin
               w_nextState = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) begin
               w_nextState = S_IDLE;
            end else if (w_lastCol) begin
               w_nextState = S_DONE;
            end else begin
               w_nextState = S_REQ;
            end
         end
         S_DONE: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Datapath. It loads the sweep on start and captures the evaluator result
   // (acks outside REQ are ignored). When a write completes it advances the
   // column and x, and counts failed columns.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col      <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_err      <= 1'b0;
         r_errCount <= '0;
      end else begin
         if (w_startAccepted) begin
            r_col      <= '0;
            r_x        <= 16'(X_MIN);
            r_errCount <= '0;
         end
         if ((r_state == S_REQ) && !abort) begin
            if (eval_ack) begin
               r_y   <= eval_y;
               r_err <= eval_err;
            end else if (w_timeout) begin
               r_y   <= '0;
               r_err <= 1'b1;
            end
         end
         if ((r_state == S_WRITE) && !abort) begin
            if (r_err && (r_errCount != ERR_MAX)) begin
               r_errCount <= r_errCount + 10'd1;
            end
            if (!w_lastCol) begin
               r_col <= r_col + 10'd1;
               r_x   <= r_x + 16'd1;
            end
         end
      end
   end

   // Output decode. The write strobe and the done pulse are suppressed in a cycle that also has abort or reset.
   always_comb begin
      eval_req = 1'b0;
      col_we   = 1'b0;
      col_data = '0;
      done     = 1'b0;
      busy     = (r_state != S_IDLE);
      case (r_state)
         S_REQ: begin
            eval_req = 1'b1;
         end
         S_WRITE: begin
            col_we   = !abort && !reset;
            col_data = {~r_err, r_y};
         end
         S_DONE: begin
            done = !abort && !reset;
         end
         default: begin
            eval_req = 1'b0;
         end
      endcase
   end

   assign eval_x    = r_x;
   assign col_addr  = r_col;
   assign err_count = r_errCount;

endmodule

// File: tb/tb_graph_plot_sequencer.sv
// Testbench for graph_plot_sequencer. The DUT is built with NUM_COLS=4 and TIMEOUT=8.
// A small evaluator model answers with y = 2*x. It can delay the ack, flag
// one column as an error, or stay silent (timeout case, GRAPH_EVAL_TIMEOUT_EN).
module tb_graph_plot_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        eval_req;
   logic [15:0] eval_x;
   logic        eval_ack;
   logic [15:0] eval_y;
   logic        eval_err;
   logic        col_we;
   logic [9:0]  col_addr;
   logic [16:0] col_data;
   logic        busy;
   logic        done;
   logic [9:0]  err_count;

   int ackDelay   = 0;
   int errCol     = 99;
   bit ackEnable  = 1'b1;
   int waitCnt    = 0;

   int checksTotal  = 0;
   int checksPassed = 0;

   int          cyc = 0;
   int          startCycle;
   int          doneCycle;
   int          firstWeCycle;
   int          wrCount;
   int          doneCnt;
   int          firstAddr;
   int          stabErr;
   int          reqRun;
   int          maxReqRun;
   logic        prevReq;
   logic [15:0] prevX;
   logic [16:0] wrData [0:3];

   graph_plot_sequencer #(
      .NUM_COLS(4),
      .X_MIN   (-310),
      .TIMEOUT (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .eval_req (eval_req),
      .eval_x   (eval_x),
      .eval_ack (eval_ack),
      .eval_y   (eval_y),
      .eval_err (eval_err),
      .col_we   (col_we),
      .col_addr (col_addr),
      .col_data (col_data),
      .busy     (busy),
      .done     (done),
      .err_count(err_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Evaluator model: y = 2*x. The ack comes after ackDelay waiting cycles, and one column may report an error.
   assign eval_ack = ackEnable && eval_req && (waitCnt >= ackDelay);
   assign eval_y   = 16'(eval_x * 2);
   assign eval_err = eval_req && (int'(col_addr) == errCol);

   // Cycle counter, plus the count of REQ cycles already waited for an ack.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (eval_req && !eval_ack) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
   end

   // Monitor, sampled mid-cycle. It records writes, the done pulse, and eval_x stability while REQ is held.
   always @(negedge clk) begin
      if (col_we) begin
         if (wrCount == 0) begin
            firstAddr    = int'(col_addr);
            firstWeCycle = cyc;
         end
         if (col_addr < 10'd4) wrData[col_addr[1:0]] = col_data;
         wrCount = wrCount + 1;
      end
      if (done) begin
         doneCnt   = doneCnt + 1;
         doneCycle = cyc;
      end
      if (eval_req && prevReq && (eval_x != prevX)) stabErr = stabErr + 1;
      reqRun = eval_req ? reqRun + 1 : 0;
      if (reqRun > maxReqRun) maxReqRun = reqRun;
      prevReq = eval_req;
      prevX   = eval_x;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checksTotal = checksTotal + 1;
      if (observed === expected) checksPassed = checksPassed + 1;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearRecords();
      wrCount      = 0;
      doneCnt      = 0;
      firstAddr    = -1;
      firstWeCycle = -1;
      doneCycle    = -1;
      stabErr      = 0;
      reqRun       = 0;
      maxReqRun    = 0;
      for (int i = 0; i < 4; i++) wrData[i] = '0;
   endtask

   task automatic applyStimulus(input logic s, input logic a);
      start = s;
      abort = a;
      tick();
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic pulseStart();
      startCycle = cyc;
      applyStimulus(1'b1, 1'b0);
   endtask

   task automatic waitDone(input int maxCycles);
      int n = 0;
      while (doneCnt == 0 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("doneSeen", doneCnt, 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ctrl"}, {eval_req, col_we, done, busy}, 4'b0000);
      checkOutput({tag, "_addr"}, col_addr, 0);
      checkOutput({tag, "_data"}, col_data, 0);
      checkOutput({tag, "_x"}, eval_x, 0);
      checkOutput({tag, "_errcnt"}, err_count, 0);
   endtask

   // Directed scenarios
   initial begin
      int wrBefore;
      int n;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      clearRecords();
      repeat (3) tick();
      reset = 1'b0;
      checkAllZero("reset");

      // Scenario 1: immediate acks, y = 2x
      clearRecords();
      pulseStart();
      checkOutput("reqLatency", eval_req, 1);
      checkOutput("firstX", eval_x, 16'hFECA);
      waitDone(100);
      checkOutput("s1_wr0", wrData[0], 17'h1FD94);
      checkOutput("s1_wr1", wrData[1], 17'h1FD96);
      checkOutput("s1_wr2", wrData[2], 17'h1FD98);
      checkOutput("s1_wr3", wrData[3], 17'h1FD9A);
      checkOutput("s1_wrCount", wrCount, 4);
      checkOutput("s1_doneLat", doneCycle - startCycle, 9);
      checkOutput("s1_errCount", err_count, 0);
      checkOutput("s1_idleBusy", busy, 0);

      // Scenario 2: column 2 reports an evaluation error
      clearRecords();
      errCol = 2;
      pulseStart();
      waitDone(100);
      errCol = 99;
      checkOutput("s2_wr1", wrData[1], 17'h1FD96);
      checkOutput("s2_wr2", wrData[2], 17'h0FD98);
      checkOutput("s2_errCount", err_count, 1);

      // Scenario 3: every ack is delayed by 5 cycles
      clearRecords();
      ackDelay = 5;
      pulseStart();
      waitDone(200);
      checkOutput("s3_stable", stabErr, 0);
      checkOutput("s3_reqRun", maxReqRun, 6);
      checkOutput("s3_wrCount", wrCount, 4);
      checkOutput("s3_doneLat", doneCycle - startCycle, 29);

      // Scenario 4: abort during the REQ of column 1, then restart
      clearRecords();
      ackDelay = 3;
      pulseStart();
      n = 0;
      while (!(eval_req && col_addr == 10'd1) && n < 50) begin
         tick();
         n++;
      end
      checkOutput("s4_reachCol1", {eval_req, col_addr}, {1'b1, 10'd1});
      applyStimulus(1'b0, 1'b1);
      checkOutput("s4_busyAfterAbort", {busy, eval_req}, 2'b00);
      repeat (20) tick();
      checkOutput("s4_wrCount", wrCount, 1);
      checkOutput("s4_noDone", doneCnt, 0);
      clearRecords();
      ackDelay = 0;
      pulseStart();
      waitDone(100);
      checkOutput("s4_restartAddr", firstAddr, 0);
      checkOutput("s4_restartCount", wrCount, 4);
      checkOutput("s4_restartWr3", wrData[3], 17'h1FD9A);

      // A start and an abort in the same IDLE cycle: abort wins
      applyStimulus(1'b1, 1'b1);
      checkOutput("abortWins", {busy, eval_req}, 2'b00);
      tick();
      checkOutput("abortWinsLater", busy, 0);

      // Scenario 5: a start mid-sweep is ignored, then a reset arrives mid-sweep
      clearRecords();
      ackDelay = 2;
      pulseStart();
      repeat (4) tick();
      applyStimulus(1'b1, 1'b0);
      waitDone(100);
      checkOutput("s5_doneLat", doneCycle - startCycle, 17);
      checkOutput("s5_wrCount", wrCount, 4);
      clearRecords();
      pulseStart();
      repeat (5) tick();
      wrBefore = wrCount;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkAllZero("s5_reset");
      repeat (20) tick();
      checkOutput("s5_noWrites", wrCount, wrBefore);
      checkOutput("s5_noDone", doneCnt, 0);
      checkOutput("s5_idle", busy, 0);

`ifdef GRAPH_EVAL_TIMEOUT_EN
      // Scenario 6: the evaluator never acks, so every column times out
      clearRecords();
      ackDelay  = 0;
      ackEnable = 1'b0;
      pulseStart();
      waitDone(200);
      ackEnable = 1'b1;
      checkOutput("s6_weLat", firstWeCycle - startCycle, 10);
      checkOutput("s6_wr0", wrData[0], 17'h00000);
      checkOutput("s6_errCount", err_count, 4);
`endif

      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
